// File: rtl/clk_div_pkg.sv
// Shared defaults and helpers for the multi-channel clock divider.
package clk_div_pkg;

  localparam int unsigned CNT_W_DEF   = 26;
  localparam int unsigned NUM_CH_DEF  = 4;
  localparam int unsigned DIV_RST_DEF = 1000;

  // Channel-select width: clog2 of the channel count, never below one bit.
  function automatic int unsigned selW(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counts to Active, toggles ClkOut, and swaps in a
// shadowed divide value only at a wrap edge so no half-period is cut short.
// Optional CLK_DIV_SYNC_EN adds a Sync input that realigns the channel.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned DIV_RST = DIV_RST_DEF
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic             WrEn,
  input  logic [CNT_W-1:0] WrData,
`ifdef CLK_DIV_SYNC_EN
  input  logic             Sync,
`endif
  output logic             ClkOut,
  output logic             Tick,
  output logic             Pend
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] active;
  logic [CNT_W-1:0] shadow;
  logic             wrap;

  // A wrap happens on an enabled cycle whose count has reached the divide value.
  assign wrap = En && (cnt == active);

  // Counter, output toggle and divide-value handoff.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt    <= '0;
      active <= CNT_W'(DIV_RST);
      shadow <= CNT_W'(DIV_RST);
      Pend   <= 1'b0;
      ClkOut <= 1'b0;
      Tick   <= 1'b0;
    end
`ifdef CLK_DIV_SYNC_EN
    else if (Sync) begin
      cnt    <= '0;
      ClkOut <= 1'b0;
      Tick   <= 1'b0;
      if (Pend) active <= shadow;
      if (WrEn) begin
        shadow <= WrData;
        Pend   <= 1'b1;
      end else begin
        Pend   <= 1'b0;
      end
    end
`endif
    else begin
      Tick <= 1'b0;
      if (En) begin
        if (wrap) begin
          cnt    <= '0;
          ClkOut <= ~ClkOut;
          Tick   <= 1'b1;
        end else begin
          cnt    <= cnt + CNT_W'(1);
        end
      end
      if (wrap) begin
        // A write landing on the wrap edge goes straight to Active.
        if (WrEn) begin
          active <= WrData;
          Pend   <= 1'b0;
        end else if (Pend) begin
          active <= shadow;
          Pend   <= 1'b0;
        end
      end else if (WrEn) begin
        shadow <= WrData;
        Pend   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// NUM_CH independent programmable clock dividers sharing one write port.
// Optional CLK_DIV_SYNC_EN adds a Sync input that realigns all channels.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH  = NUM_CH_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned DIV_RST = DIV_RST_DEF
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic [NUM_CH-1:0]           En,
  input  logic                        WrEn,
  input  logic [selW(NUM_CH)-1:0]     WrSel,
  input  logic [CNT_W-1:0]            WrData,
`ifdef CLK_DIV_SYNC_EN
  input  logic                        Sync,
`endif
  output logic [NUM_CH-1:0]           ClkOut,
  output logic [NUM_CH-1:0]           Tick,
  output logic [NUM_CH-1:0]           Pend
);

  localparam int unsigned SEL_W = selW(NUM_CH);

  logic [NUM_CH-1:0] wrStb;

  // Decode the write select; out-of-range selects match no channel.
  always_comb begin
    wrStb = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (WrEn && (WrSel == SEL_W'(i))) wrStb[i] = 1'b1;
    end
  end

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : gCh
    clk_div_ch #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_RST)
    ) uCh (
      .Clk    (Clk),
      .Rst    (Rst),
      .En     (En[g]),
      .WrEn   (wrStb[g]),
      .WrData (WrData),
`ifdef CLK_DIV_SYNC_EN
      .Sync   (Sync),
`endif
      .ClkOut (ClkOut[g]),
      .Tick   (Tick[g]),
      .Pend   (Pend[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi against a countdown-style reference model.
module tb_clk_div_multi;

  localparam int unsigned NCH  = 3;
  localparam int unsigned CW   = 8;
  localparam int unsigned DRST = 3;
  localparam int unsigned SW   = 2;
`ifdef CLK_DIV_SYNC_EN
  localparam bit SYNC_ON = 1'b1;
`else
  localparam bit SYNC_ON = 1'b0;
`endif

  logic           Clk;
  logic           Rst;
  logic [NCH-1:0] En;
  logic           WrEn;
  logic [SW-1:0]  WrSel;
  logic [CW-1:0]  WrData;
  logic           Sync;
  logic [NCH-1:0] ClkOut;
  logic [NCH-1:0] Tick;
  logic [NCH-1:0] Pend;

  clk_div_multi #(
    .NUM_CH  (NCH),
    .CNT_W   (CW),
    .DIV_RST (DRST)
  ) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .En     (En),
    .WrEn   (WrEn),
    .WrSel  (WrSel),
    .WrData (WrData),
`ifdef CLK_DIV_SYNC_EN
    .Sync   (Sync),
`endif
    .ClkOut (ClkOut),
    .Tick   (Tick),
    .Pend   (Pend)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef logic [3*NCH-1:0] exp_t;
  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: cycles left in the current half-period, output level,
  // divide value in force, and a pending replacement.
  int remain [NCH];
  int divM   [NCH];
  int shadowM[NCH];
  bit lvl    [NCH];
  bit tickM  [NCH];
  bit pendM  [NCH];

  task automatic step(input bit rst, input logic [NCH-1:0] en, input bit wr,
                      input int sel, input int data, input bit sync);
    exp_t e;
    bit   w;
    bit   wrapNow;
    bit   syncAct;
    @(negedge Clk);
    Rst    = rst;
    En     = en;
    WrEn   = wr;
    WrSel  = SW'(sel);
    WrData = CW'(data);
    Sync   = sync;
    syncAct = sync && SYNC_ON;
    for (int i = 0; i < int'(NCH); i++) begin
      w = wr && (sel == i);
      if (rst) begin
        divM[i] = DRST; shadowM[i] = DRST; remain[i] = DRST + 1;
        lvl[i] = 1'b0; tickM[i] = 1'b0; pendM[i] = 1'b0;
      end else if (syncAct) begin
        tickM[i] = 1'b0;
        lvl[i]   = 1'b0;
        if (pendM[i]) divM[i] = shadowM[i];
        pendM[i] = 1'b0;
        if (w) begin shadowM[i] = data; pendM[i] = 1'b1; end
        remain[i] = divM[i] + 1;
      end else begin
        tickM[i] = 1'b0;
        wrapNow  = en[i] && (remain[i] == 1);
        if (en[i]) begin
          remain[i]--;
          if (remain[i] == 0) begin
            lvl[i]   = ~lvl[i];
            tickM[i] = 1'b1;
            if (w) divM[i] = data;
            else if (pendM[i]) divM[i] = shadowM[i];
            pendM[i]  = 1'b0;
            remain[i] = divM[i] + 1;
          end
        end
        if (w && !wrapNow) begin shadowM[i] = data; pendM[i] = 1'b1; end
      end
      e[i]         = lvl[i];
      e[NCH+i]     = tickM[i];
      e[2*NCH+i]   = pendM[i];
    end
    expQ.push_back(e);
  endtask

  // Monitor: compare each registered output set against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      cyc++;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checks += 3;
        if (ClkOut !== e[NCH-1:0]) begin
          errors++;
          $display("FAIL ClkOut cycle %0d: got %b expected %b", cyc, ClkOut, e[NCH-1:0]);
        end
        if (Tick !== e[2*NCH-1:NCH]) begin
          errors++;
          $display("FAIL Tick cycle %0d: got %b expected %b", cyc, Tick, e[2*NCH-1:NCH]);
        end
        if (Pend !== e[3*NCH-1:2*NCH]) begin
          errors++;
          $display("FAIL Pend cycle %0d: got %b expected %b", cyc, Pend, e[3*NCH-1:2*NCH]);
        end
      end
    end
  end

  localparam logic [NCH-1:0] ALL = '1;

  initial begin
    Rst = 1'b1; En = '0; WrEn = 1'b0; WrSel = '0; WrData = '0; Sync = 1'b0;
    // Reset, then free-run: period 8, all channels in phase.
    step(1, '0, 0, 0, 0, 0);
    step(1, ALL, 1, 0, 9, 0);
    for (int k = 0; k < 20; k++) step(0, ALL, 0, 0, 0, 0);
    // Write 0 to channel 1 at Cnt=1: pending until the wrap.
    step(1, '0, 0, 0, 0, 0);
    step(0, ALL, 0, 0, 0, 0);
    step(0, ALL, 1, 1, 0, 0);
    for (int k = 0; k < 10; k++) step(0, ALL, 0, 0, 0, 0);
    // Write 5 to channel 2 exactly on its wrap edge.
    step(1, '0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, ALL, 0, 0, 0, 0);
    step(0, ALL, 1, 2, 5, 0);
    for (int k = 0; k < 16; k++) step(0, ALL, 0, 0, 0, 0);
    // Freeze channel 0 for 7 cycles mid-count.
    step(1, '0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) step(0, ALL, 0, 0, 0, 0);
    for (int k = 0; k < 7; k++) step(0, 3'b110, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) step(0, ALL, 0, 0, 0, 0);
    // Out-of-range select is ignored.
    step(0, ALL, 1, int'(NCH), 1, 0);
    for (int k = 0; k < 6; k++) step(0, ALL, 0, 0, 0, 0);
    // Sync realignment and Rst-over-Sync (only meaningful with Sync present).
    if (SYNC_ON) begin
      step(0, 3'b101, 1, 0, 1, 0);
      for (int k = 0; k < 5; k++) step(0, ALL, 0, 0, 0, 0);
      step(0, ALL, 1, 1, 2, 1);
      for (int k = 0; k < 8; k++) step(0, ALL, 0, 0, 0, 0);
      step(1, ALL, 1, 0, 4, 1);
      for (int k = 0; k < 4; k++) step(0, ALL, 0, 0, 0, 0);
    end
    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(63, 0) == 0),
           (($urandom_range(3, 0) == 0) ? NCH'($urandom) : ALL),
           ($urandom_range(3, 0) == 0),
           int'($urandom_range(3, 0)),
           int'($urandom_range(6, 0)),
           ($urandom_range(47, 0) == 0));
    end
    @(negedge Clk);
    @(negedge Clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent divider channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 26: counter and divide-value width.
REQ-003 SHALL have parameter DIV_RST, default 1000: divide value loaded into every channel at reset.
REQ-004 SHALL have port Clk  in  1: single clock; all logic on posedge Clk.
REQ-005 SHALL have port Rst  in  1: reset, synchronous, active-high.
REQ-006 SHALL have port En  in  NUM_CH: per-channel count enable.
REQ-007 SHALL have port WrEn  in  1: divide-value write strobe.
REQ-008 SHALL have port WrSel  in  clog2(NUM_CH) (min 1): target channel of the write.
REQ-009 SHALL have port WrData  in  CNT_W: new divide value.
REQ-010 SHALL have port ClkOut  out  NUM_CH: registered divided clock per channel.
REQ-011 SHALL have port Tick  out  NUM_CH: registered one-cycle pulse per ClkOut toggle.
REQ-012 SHALL have port Pend  out  NUM_CH: write accepted but not yet applied.

Function
REQ-013 Each channel SHALL hold Cnt, Active (divide value), Shadow, Pend, ClkOut, Tick.
REQ-014 With En[i]=1 and Cnt==Active, the next edge SHALL give Cnt<=0, ClkOut[i]<=~ClkOut[i], Tick[i]<=1.
REQ-015 With En[i]=1 and Cnt!=Active, the next edge SHALL give Cnt<=Cnt+1, ClkOut[i] held, Tick[i]<=0.
REQ-016 Half-period SHALL be Active+1 cycles and full period 2*(Active+1); Active=0 SHALL toggle ClkOut every cycle.
REQ-017 With En[i]=0, Cnt and ClkOut[i] SHALL hold, Tick[i] SHALL be 0, and the pending state SHALL hold.
REQ-018 WrEn=1 with WrSel<NUM_CH SHALL load Shadow<=WrData and set Pend for that channel on the next edge.
REQ-019 WrEn=1 with WrSel>=NUM_CH SHALL be ignored with no state change.
REQ-020 At a wrap edge (REQ-014) with Pend=1, the channel SHALL apply Active<=Shadow and clear Pend, so a period is never truncated or stretched mid-phase.
REQ-021 A write to a channel on its own wrap edge SHALL bypass Shadow: Active<=WrData, Pend<=0.
REQ-022 A second write before the wrap SHALL overwrite Shadow; the last value wins.
REQ-023 Cnt SHALL never exceed Active, because Active changes only at Cnt==0 boundaries.
REQ-024 All outputs SHALL be driven directly from flops, with no combinational path from any input to any output.

Reset
REQ-025 When Rst=1 at posedge Clk, every channel SHALL set Cnt=0, Active=Shadow=DIV_RST, Pend=0, ClkOut=0, Tick=0.
REQ-026 Rst SHALL take priority over the Sync input, writes and En; a write in the reset cycle SHALL be lost.
REQ-027 Reset mid-period SHALL restart the channel from phase 0 with the low half of the period.

Configuration
REQ-028 With CLK_DIV_SYNC_EN defined, the block SHALL have an input port Sync (1 bit).
REQ-029 With CLK_DIV_SYNC_EN defined, Sync=1 SHALL set Cnt=0, ClkOut=0 and Tick=0 in all channels, and apply any pending Shadow to Active.
REQ-030 Sync SHALL act regardless of En.
REQ-031 Sync SHALL be overridden by Rst.
REQ-032 Sync SHALL beat a same-cycle write, which SHALL land in Shadow with Pend=1.
REQ-033 Without CLK_DIV_SYNC_EN, the Sync port and its logic SHALL be absent, and behaviour SHALL be REQ-001 to REQ-027 only.

Structure
REQ-034 Package clk_div_pkg SHALL hold the default CNT_W, NUM_CH and DIV_RST constants, and the channel-select width function (clog2, min 1).
REQ-035 One sub-module, clk_div_ch, SHALL implement a single channel; clk_div_multi SHALL instantiate NUM_CH of them and decode WrSel into per-channel write strobes.

Verification
REQ-036 Rst pulse, then En=all ones with DIV_RST=3 -> ClkOut toggles every 4 cycles with period 8, Tick high 1 cycle per toggle, channels in phase.
REQ-037 Write 0 to channel 1 at Cnt=1 with Active=3 -> Pend[1]=1 until the wrap; channel 1 then toggles every cycle with no short half-period; other channels unaffected.
REQ-038 Write 5 to channel 2 exactly on its wrap edge -> Pend[2] never rises; the next half-period is 6 cycles.
REQ-039 En[0]=0 for 7 cycles mid-count -> ClkOut[0] frozen, Tick[0]=0, and counting resumes from the held Cnt.
REQ-040 WrSel=NUM_CH with WrEn=1 -> no Pend bit set and all channels unchanged.
REQ-041 (CLK_DIV_SYNC_EN) Channels at different phases, then Sync=1 for one cycle -> all Cnt=0 and ClkOut=0, all channels identical afterwards; Rst=1 and Sync=1 together -> reset values.
